// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbitration of functional-unit results onto a single registered common data bus.
module cdb_arbiter #(
  parameter int NUM_FU = 4,
  parameter int XLEN   = 32,
  parameter int TAG_W  = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_FU-1:0]         fu_done,
  input  logic [NUM_FU*XLEN-1:0]    fu_value,
  input  logic [NUM_FU*TAG_W-1:0]   fu_rob_tag,
  input  logic                      cdb_stall,
  input  logic                      squash,
  output logic [NUM_FU-1:0]         fu_ack,
  output logic                      cdb_valid,
  output logic [XLEN-1:0]           cdb_value,
  output logic [TAG_W-1:0]          cdb_rob_tag,
  output logic [$clog2(NUM_FU)-1:0] cdb_fu_idx,
  output logic [31:0]               bcast_count
);
  localparam int IDX_W = $clog2(NUM_FU);
  logic [IDX_W-1:0] ptr, win, win_nxt;
  logic             found, grant;
  logic [XLEN-1:0]  mux_value;
  logic [TAG_W-1:0] mux_tag;
  // Scanning from the farthest offset down lets the nearest set bit overwrite, avoiding a break.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      if (fu_done[IDX_W'((int'(ptr) + k) % NUM_FU)]) begin
        win   = IDX_W'((int'(ptr) + k) % NUM_FU);
        found = 1'b1;
      end
    end
  end
  assign win_nxt = (int'(win) == NUM_FU - 1) ? '0 : win + 1'b1;
  assign grant   = found & ~cdb_stall & ~squash & ~reset;
  assign fu_ack  = grant ? ({{(NUM_FU-1){1'b0}}, 1'b1} << win) : '0;
  // AND-OR mux driven only by the one-hot ack, so ungranted data never reaches the bus.
  always_comb begin
    mux_value = '0;
    mux_tag   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      mux_value = mux_value | (fu_value[i*XLEN +: XLEN] & {XLEN{fu_ack[i]}});
      mux_tag   = mux_tag | (fu_rob_tag[i*TAG_W +: TAG_W] & {TAG_W{fu_ack[i]}});
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      cdb_valid   <= 1'b0;
      cdb_value   <= '0;
      cdb_rob_tag <= '0;
      cdb_fu_idx  <= '0;
      bcast_count <= '0;
      ptr         <= '0;
    end else begin
      cdb_valid <= grant;
      if (grant) begin
        cdb_value   <= mux_value;
        cdb_rob_tag <= mux_tag;
        cdb_fu_idx  <= win;
        bcast_count <= bcast_count + 32'd1;
        ptr         <= win_nxt;
      end
      if (squash) ptr <= '0;
    end
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between NUM_FU functional units, including the pipelined multiplier FUs.
- Each FU holds its done level until it is acked. This block picks one done FU per cycle with a round-robin scheme and returns a one-cycle ack to it.
- The winner's value and ROB tag are registered onto the CDB for the ROB and reservation stations.
- Squash and stall inputs let the pipeline control flush and back-pressure the bus.

Parameters:
- NUM_FU, 4, number of requesting functional units (>=2).
- XLEN, 32, width of the result value.
- TAG_W, 5, width of the ROB tag.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- fu_done  in  NUM_FU  bit i high = FU i holds a completed result; held until acked.
- fu_value  in  NUM_FU*XLEN  FU i result in slice [i*XLEN +: XLEN].
- fu_rob_tag  in  NUM_FU*TAG_W  FU i ROB tag in slice [i*TAG_W +: TAG_W].
- cdb_stall  in  1  high = no grant this cycle.
- squash  in  1  branch-mispredict flush.
- fu_ack  out  NUM_FU  one-hot or zero, combinational grant to FU i.
- cdb_valid  out  1  registered: CDB carries a valid broadcast.
- cdb_value  out  XLEN  registered broadcast value.
- cdb_rob_tag  out  TAG_W  registered broadcast tag.
- cdb_fu_idx  out  $clog2(NUM_FU)  registered index of the winning FU.
- bcast_count  out  32  number of broadcasts since reset.

Behaviour:
- Reset (synchronous, active-high): clears the following, all taking effect at that edge.
  - cdb_valid, cdb_value, cdb_rob_tag and cdb_fu_idx = 0.
  - Priority pointer ptr = 0.
  - bcast_count = 0.
  - fu_ack = 0 while reset is high.
- Grant (combinational):
  - Search fu_done starting at index ptr, moving upward and wrapping modulo NUM_FU.
  - The first set bit wins: fu_ack[win] = 1, all other ack bits 0.
  - fu_ack = 0 if any of these hold: no done bits set, cdb_stall = 1, squash = 1, or reset = 1.
- Pointer update at the clock edge:
  - After a grant to win, ptr <= (win+1) mod NUM_FU, wrapping from NUM_FU-1 to 0.
  - Without a grant, ptr holds.
  - On squash, ptr <= 0.
- Broadcast latency: one cycle. When the grant is to win at edge k, at edge k:
  - cdb_valid <= 1.
  - cdb_value <= fu_value slice win.
  - cdb_rob_tag <= fu_rob_tag slice win.
  - cdb_fu_idx <= win.
  - bcast_count <= bcast_count + 1, wrapping at 2^32.
- No grant in a cycle: cdb_valid <= 0 at the next edge; the data registers hold their old value (don't-care).
- Ack contract: the FU clears fu_done at the same edge the ack is sampled. The arbiter never re-grants the same FU in the following cycle unless that FU raises done again. A bench must flag two acks to one FU on consecutive cycles while its done stayed high across the edge.
- Fairness: while cdb_stall = 0 and squash = 0, a continuously asserted fu_done[i] is acked within NUM_FU cycles.
- Simultaneous events:
  - squash and a done bit together: no ack, cdb_valid <= 0 at the next edge, ptr <= 0.
  - cdb_stall and squash together: squash rules apply.
  - A broadcast already registered in the current cycle is not cancelled by a squash in that cycle. Downstream blocks filter it by tag.
- Stall: fu_ack = 0 and cdb_valid <= 0 at the next edge. FUs keep their done bits and are served after the stall ends; ptr is unchanged.
- Reset mid-broadcast: cdb_valid = 0 after the edge. FUs still holding done are served normally after reset, starting from index 0.
- Datapath muxing uses only the one-hot grant. Values from non-granted FUs never reach the CDB.
- No latches; all registers are updated in a single clocked process plus a combinational grant process.

Test Plan:
- Reset then idle: reset for 2 cycles, fu_done = 0000 -> fu_ack = 0000, cdb_valid = 0, bcast_count = 0 for 10 cycles.
- Single request: fu_done = 0100 with value 0x0000_002A, tag 3, held until acked -> fu_ack = 0100 in that cycle; next cycle cdb_valid = 1, cdb_value = 0x2A, cdb_rob_tag = 3, cdb_fu_idx = 2; ptr = 3; bcast_count = 1.
- Round-robin: all four done bits held high, each FU re-raising done immediately after its ack -> acks in order FU0, FU1, FU2, FU3, FU0 on consecutive cycles; cdb_fu_idx sequence 0, 1, 2, 3, 0 one cycle later.
- Wrap-around: ptr = 3 (after granting FU2), fu_done = 0011 -> grant FU0, then FU1; ptr ends at 2.
- Stall: fu_done = 1000 with cdb_stall = 1 for 3 cycles -> fu_ack = 0 and cdb_valid = 0 throughout; on the first unstalled cycle fu_ack = 1000, and cdb_valid = 1 with idx 3 the next cycle.
- Squash and mid-operation reset:
  - squash together with fu_done = 0110 -> no ack, next-cycle cdb_valid = 0, ptr = 0; the following cycle grants FU1.
  - reset asserted during a broadcast -> cdb_valid = 0 and bcast_count = 0 after the edge.
